// File: rtl/nv_nvdla_sdp_hls_y_inp_cvt_out.sv
// SDP Y-path interpolation output converter: per-lane round/shift, saturate to OUT_W,
// two-stage valid/ready pipeline, plus a saturation event counter for the register file.
module nv_nvdla_sdp_hls_y_inp_cvt_out #(
    parameter int THROUGHPUT = 2,
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    input  logic                        cvt_in_pvld,
    output logic                        cvt_in_prdy,
    input  logic [THROUGHPUT*IN_W-1:0]  cvt_in_pd,
    output logic                        cvt_out_pvld,
    input  logic                        cvt_out_prdy,
    output logic [THROUGHPUT*OUT_W-1:0] cvt_out_pd,
    input  logic [4:0]                  cfg_cvt_shift,
    input  logic                        sat_cnt_clr,
    output logic [31:0]                 sat_cnt
);

    // One guard bit so that the largest positive input plus the rounding constant cannot overflow.
    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX  = EXT_W'(2**(OUT_W-1) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN  = EXT_W'(-(2**(OUT_W-1)));
    localparam logic [OUT_W-1:0]        MAX_CODE = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        MIN_CODE = {1'b1, {(OUT_W-1){1'b0}}};

    logic s1_vld;
    logic s2_vld;
    logic s1_en;
    logic s2_en;
    logic out_xfer;

    logic signed [EXT_W-1:0]              rnd;
    logic [THROUGHPUT-1:0][EXT_W-1:0]     s1_sum;
    logic [THROUGHPUT-1:0][EXT_W-1:0]     s1_nxt;
    logic [THROUGHPUT-1:0][EXT_W-1:0]     s1_data;
    logic [THROUGHPUT-1:0][OUT_W-1:0]     s2_nxt;
    logic [THROUGHPUT-1:0][OUT_W-1:0]     s2_data;
    logic [THROUGHPUT-1:0]                sat_nxt;
    logic [THROUGHPUT-1:0]                s2_sat;
    logic [31:0]                          pop;
    logic [32:0]                          cnt_sum;

    assign s2_en        = !s2_vld || cvt_out_prdy;
    assign s1_en        = !s1_vld || s2_en;
    assign cvt_in_prdy  = s1_en;
    assign cvt_out_pvld = s2_vld;
    assign cvt_out_pd   = s2_data;
    assign out_xfer     = s2_vld && cvt_out_prdy;

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        rnd = '0;
        if (cfg_cvt_shift != 5'd0) begin
            rnd = EXT_W'(1) << (cfg_cvt_shift - 5'd1);
        end
        for (int i = 0; i < THROUGHPUT; i++) begin
            s1_sum[i] = EXT_W'($signed(cvt_in_pd[i*IN_W +: IN_W])) + rnd;
            s1_nxt[i] = $signed(s1_sum[i]) >>> cfg_cvt_shift;
        end
    end

    always_comb begin
        s2_nxt  = '0;
        sat_nxt = '0;
        for (int i = 0; i < THROUGHPUT; i++) begin
            if ($signed(s1_data[i]) > SAT_MAX) begin
                s2_nxt[i]  = MAX_CODE;
                sat_nxt[i] = 1'b1;
            end else if ($signed(s1_data[i]) < SAT_MIN) begin
                s2_nxt[i]  = MIN_CODE;
                sat_nxt[i] = 1'b1;
            end else begin
                s2_nxt[i]  = s1_data[i][OUT_W-1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < THROUGHPUT; i++) begin
            pop = pop + 32'(s2_sat[i]);
        end
        cnt_sum = {1'b0, sat_cnt} + {1'b0, pop};
    end

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else begin
            if (s1_en) begin
                s1_vld <= cvt_in_pvld;
            end
            if (s1_en && cvt_in_pvld) begin
                s1_data <= s1_nxt;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s2_vld  <= 1'b0;
            s2_data <= '0;
            s2_sat  <= '0;
        end else begin
            if (s2_en) begin
                s2_vld <= s1_vld;
            end
            if (s2_en && s1_vld) begin
                s2_data <= s2_nxt;
                s2_sat  <= sat_nxt;
            end
        end
    end

    // Clear wins over accumulation, but a coincident transfer still contributes its own count.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            sat_cnt <= '0;
        end else if (sat_cnt_clr) begin
            sat_cnt <= out_xfer ? pop : 32'd0;
        end else if (out_xfer) begin
            sat_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end

endmodule

// File: tb/tb_nv_nvdla_sdp_hls_y_inp_cvt_out.sv
// Self-checking bench for nv_nvdla_sdp_hls_y_inp_cvt_out: directed corner cases followed by
// randomized traffic scored against an arithmetic reference model and a transfer queue.
module tb_nv_nvdla_sdp_hls_y_inp_cvt_out;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cvt_in_pvld;
    logic        cvt_in_prdy;
    logic [63:0] cvt_in_pd;
    logic        cvt_out_pvld;
    logic        cvt_out_prdy;
    logic [31:0] cvt_out_pd;
    logic [4:0]  cfg_cvt_shift;
    logic        sat_cnt_clr;
    logic [31:0] sat_cnt;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    typedef struct {
        logic [31:0] pd;
        int          sats;
    } exp_t;

    exp_t   exp_q[$];
    longint model_cnt = 0;

    always #5 clk = ~clk;

    nv_nvdla_sdp_hls_y_inp_cvt_out dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .cvt_in_pvld     (cvt_in_pvld),
        .cvt_in_prdy     (cvt_in_prdy),
        .cvt_in_pd       (cvt_in_pd),
        .cvt_out_pvld    (cvt_out_pvld),
        .cvt_out_prdy    (cvt_out_prdy),
        .cvt_out_pd      (cvt_out_pd),
        .cfg_cvt_shift   (cfg_cvt_shift),
        .sat_cnt_clr     (sat_cnt_clr),
        .sat_cnt         (sat_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Round-half-up divide by 2^sh using floor division, then clamp to the 16-bit signed range.
    function automatic logic [15:0] ref_lane(input logic [31:0] x, input int sh, output int sat);
        longint v, d, q;
        v = longint'($signed(x));
        d = longint'(1) << sh;
        if (sh > 0) v = v + d / 2;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        sat = 0;
        if (q > 32767) begin
            q   = 32767;
            sat = 1;
        end else if (q < -32768) begin
            q   = -32768;
            sat = 1;
        end
        return q[15:0];
    endfunction

    function automatic exp_t ref_xfer(input logic [63:0] pd, input int sh);
        exp_t e;
        int   s;
        e.sats = 0;
        for (int i = 0; i < 2; i++) begin
            e.pd[i*16 +: 16] = ref_lane(pd[i*32 +: 32], sh, s);
            e.sats += s;
        end
        return e;
    endfunction

    // Scoreboard monitor: samples handshakes on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            int  pop;
            bit  out_x;
            check("sat_cnt", sat_cnt, model_cnt[31:0]);
            check("in_prdy", cvt_in_prdy, (exp_q.size() < 2) || cvt_out_prdy);
            out_x = 1'b0;
            pop   = 0;
            if (cvt_out_pvld) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", cvt_out_pvld, 1'b0);
                end else begin
                    check("out_pd", cvt_out_pd, exp_q[0].pd);
                    out_x = cvt_out_prdy;
                    if (out_x) pop = exp_q[0].sats;
                end
            end
            if (sat_cnt_clr) begin
                model_cnt = pop;
            end else if (out_x) begin
                model_cnt = model_cnt + pop;
                if (model_cnt > 64'hFFFF_FFFF) model_cnt = 64'hFFFF_FFFF;
            end
            if (out_x) void'(exp_q.pop_front());
            if (cvt_in_pvld && cvt_in_prdy) exp_q.push_back(ref_xfer(cvt_in_pd, int'(cfg_cvt_shift)));
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the data, pvld left high.
    task automatic send(input logic [31:0] l1, input logic [31:0] l0, input logic [4:0] sh);
        bit acc;
        acc           = 1'b0;
        cvt_in_pd     = {l1, l0};
        cfg_cvt_shift = sh;
        cvt_in_pvld   = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = cvt_in_prdy;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", acc, 1'b1);
    endtask

    task automatic directed(input logic [31:0] l1, input logic [31:0] l0, input logic [4:0] sh,
                            input logic [31:0] exp_pd);
        cvt_out_prdy = 1'b1;
        send(l1, l0, sh);
        cvt_in_pvld = 1'b0;
        @(negedge clk);
        check("lat_cycle1_vld", cvt_out_pvld, 1'b0);
        @(negedge clk);
        check("lat_cycle2_vld", cvt_out_pvld, 1'b1);
        check("directed_pd", cvt_out_pd, exp_pd);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_lane();
        logic [31:0] corners [4];
        logic [31:0] v;
        corners[0] = 32'h7FFF_FFFF;
        corners[1] = 32'h8000_0000;
        corners[2] = 32'h0000_0000;
        corners[3] = 32'hFFFF_FFFF;
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = 32'($signed(16'($urandom)));
            2:       v = corners[$urandom_range(0, 3)];
            default: v = 32'($signed(18'($urandom)));
        endcase
        return v;
    endfunction

    initial begin
        rstn          = 1'b1;
        cvt_in_pvld   = 1'b0;
        cvt_in_pd     = '0;
        cvt_out_prdy  = 1'b0;
        cfg_cvt_shift = '0;
        sat_cnt_clr   = 1'b0;
        #1 rstn = 1'b0;
        #2;
        check("rst_out_pvld", cvt_out_pvld, 1'b0);
        check("rst_out_pd", cvt_out_pd, 32'h0);
        check("rst_sat_cnt", sat_cnt, 32'h0);
        check("rst_in_prdy", cvt_in_prdy, 1'b1);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        directed(32'hFFFF_FFFE, 32'h0000_1234, 5'd0, 32'hFFFE_1234);
        @(negedge clk);
        check("t1_sat_cnt", sat_cnt, 32'd0);
        @(posedge clk); #1;
        directed(32'hFFFF_FFF8, 32'h0000_0018, 5'd4, 32'h0000_0002);
        directed(32'h8000_0000, 32'h0001_0000, 5'd0, 32'h8000_7FFF);
        @(negedge clk);
        check("t3_sat_cnt", sat_cnt, 32'd2);
        @(posedge clk); #1;
        directed(32'h8000_0000, 32'h7FFF_FFFF, 5'd31, 32'hFFFF_0001);
        @(negedge clk);
        check("t4_sat_cnt", sat_cnt, 32'd2);
        @(posedge clk); #1;

        // Back-to-back stream into a stalled output.
        cvt_out_prdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                @(negedge clk);
                check("stall_in_prdy", cvt_in_prdy, 1'b0);
                repeat (3) @(negedge clk);
                @(posedge clk); #1;
                cvt_out_prdy = 1'b1;
            end
            send(32'(-(i * 777)), 32'(i * 1000 + 3), 5'd2);
        end
        cvt_in_pvld = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("stall_drain", exp_q.size(), 0);
        @(posedge clk); #1;

        // Clear coinciding with a transfer that saturates one lane.
        check("pre_clr_nonzero", sat_cnt != 0, 1'b1);
        cvt_out_prdy = 1'b1;
        send(32'h0000_0000, 32'h0001_0000, 5'd0);
        cvt_in_pvld = 1'b0;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_with_xfer", sat_cnt, 32'd1);
        @(posedge clk); #1;

        // Reset with both stages full.
        cvt_out_prdy = 1'b0;
        send(32'h7FFF_FFFF, 32'h8000_0000, 5'd0);
        send(32'h0000_0001, 32'h0000_0002, 5'd0);
        #1;
        rstn        = 1'b0;
        cvt_in_pvld = 1'b0;
        #1;
        check("midrst_out_pvld", cvt_out_pvld, 1'b0);
        check("midrst_sat_cnt", sat_cnt, 32'h0);
        check("midrst_out_pd", cvt_out_pd, 32'h0);
        check("midrst_in_prdy", cvt_in_prdy, 1'b1);
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk); #1;
        rstn         = 1'b1;
        cvt_out_prdy = 1'b1;
        @(negedge clk);
        check("postrst_in_prdy", cvt_in_prdy, 1'b1);
        check("postrst_out_pvld", cvt_out_pvld, 1'b0);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure, shifts and clears.
        for (int c = 0; c < 3000; c++) begin
            cvt_in_pvld   = ($urandom_range(0, 3) != 0);
            cvt_in_pd     = {rand_lane(), rand_lane()};
            cfg_cvt_shift = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) != 0) ? 5'd31 : 5'd0)
                                                        : 5'($urandom_range(0, 31));
            cvt_out_prdy  = ($urandom_range(0, 2) != 0);
            sat_cnt_clr   = ($urandom_range(0, 63) == 0);
            @(posedge clk); #1;
        end
        cvt_in_pvld  = 1'b0;
        cvt_out_prdy = 1'b1;
        sat_cnt_clr  = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("final_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
